// File: rtl/scpu_pkg.sv
// Shared definitions for the scpu control path: sequencer states,
// instruction field positions and the halt opcode.
package scpu_pkg;

   localparam int unsigned INSTR_W = 32;

   // Instruction field positions, shared with scpu_decoder
   localparam int unsigned OPC_LSB = 0;
   localparam int unsigned OPC_MSB = 6;
   localparam int unsigned RD_LSB  = 7;
   localparam int unsigned RD_MSB  = 11;

   localparam int unsigned OPC_W = OPC_MSB - OPC_LSB + 1;
   localparam int unsigned RD_W  = RD_MSB - RD_LSB + 1;

   localparam logic [OPC_W-1:0] OPC_HALT = 7'h7F;

   // Sequencer phases
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } seq_state_t;

endpackage : scpu_pkg

// File: rtl/scpu_sequencer.sv
// Multi-cycle control sequencer: fetch over req/ack, then DECODE/EXEC/WB,
// with run/single-step/halt control and a retired-instruction counter.
module scpu_sequencer
   import scpu_pkg::*;
#(
   parameter int unsigned PC_WIDTH  = 16,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 step,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_W-1:0]   imem_rdata,
   output logic [INSTR_W-1:0]   iReg,
   output logic                 rf_we,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 busy,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] retired
);

   seq_state_t             state_q,   state_d;
   logic [PC_WIDTH-1:0]    pc_q,      pc_d;
   logic [INSTR_W-1:0]     ireg_q,    ireg_d;
   logic [CNT_WIDTH-1:0]   retired_q, retired_d;
   logic                   single_q,  single_d;
   logic                   imem_req_q, imem_req_d;
   logic                   rf_we_q,   rf_we_d;
   logic                   busy_q,    busy_d;
   logic                   halted_q,  halted_d;

   logic [OPC_W-1:0]       opcode;
   logic [RD_W-1:0]        rd;

   assign opcode = ireg_q[OPC_MSB:OPC_LSB];
   assign rd     = ireg_q[RD_MSB:RD_LSB];

   // Next-state, datapath updates and registered-output precompute
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ireg_d    = ireg_q;
      retired_d = retired_q;
      single_d  = single_q;
      rf_we_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end else if (step) begin
               state_d  = ST_FETCH;
               single_d = 1'b1;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               ireg_d  = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = (opcode == OPC_HALT) ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            // Write strobe is registered, so it is raised on entry to WB
            state_d = ST_WB;
            rf_we_d = (rd != RD_W'(0));
         end
         ST_WB: begin
            pc_d      = pc_q + PC_WIDTH'(1);
            retired_d = retired_q + CNT_WIDTH'(1);
            if (run && !single_q) begin
               state_d = ST_FETCH;
            end else begin
               state_d  = ST_IDLE;
               single_d = 1'b0;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      imem_req_d = (state_d == ST_FETCH);
      busy_d     = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                   (state_d == ST_EXEC)  || (state_d == ST_WB);
      halted_d   = (state_d == ST_HALT);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         ireg_q     <= '0;
         retired_q  <= '0;
         single_q   <= 1'b0;
         imem_req_q <= 1'b0;
         rf_we_q    <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ireg_q     <= ireg_d;
         retired_q  <= retired_d;
         single_q   <= single_d;
         imem_req_q <= imem_req_d;
         rf_we_q    <= rf_we_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign iReg      = ireg_q;
   assign rf_we     = rf_we_q;
   assign pc        = pc_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign retired   = retired_q;

endmodule : scpu_sequencer

// File: tb/tb_scpu_sequencer.sv
// Directed plus randomized bench for scpu_sequencer with a per-instruction
// reference model (expected pc, retired count, write strobe, phase timing).
module tb_scpu_sequencer;

   logic        clk;
   logic        rst, run, step, imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_req, rf_we, busy, halted;
   logic [15:0] imem_addr, pc;
   logic [31:0] iReg, retired;

   // Narrow-PC instance used to observe PC wrap-around quickly
   logic        w_rst, w_run, w_step, w_ack;
   logic [31:0] w_rdata;
   logic        w_req, w_rf_we, w_busy, w_halted;
   logic [2:0]  w_addr, w_pc;
   logic [31:0] w_ireg, w_retired;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] exp_pc;
   logic [31:0] exp_ret;
   bit          single_m;
   bit          in_idle;

   scpu_sequencer #(.PC_WIDTH(16), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .iReg(iReg), .rf_we(rf_we), .pc(pc),
      .busy(busy), .halted(halted), .retired(retired)
   );

   scpu_sequencer #(.PC_WIDTH(3), .CNT_WIDTH(32)) u_wrap (
      .clk(clk), .rst(w_rst), .run(w_run), .step(w_step),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
      .imem_rdata(w_rdata), .iReg(w_ireg), .rf_we(w_rf_we), .pc(w_pc),
      .busy(w_busy), .halted(w_halted), .retired(w_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Acts as instruction memory for one instruction and checks every phase
   task automatic do_instr(input logic [31:0] word, input int waits,
                           input bit run_next, input bit spurious,
                           input bit step_in_fetch);
      int  guard;
      bit  cont;
      guard = 0;
      while (imem_req !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      chk("fetch_req", 64'(imem_req), 64'(1));
      chk("fetch_addr", 64'(imem_addr), 64'(exp_pc));
      chk("fetch_busy", 64'(busy), 64'(1));
      if (step_in_fetch) step = 1'b1;
      for (int w = 0; w < waits; w++) begin
         imem_ack = 1'b0;
         tick();
         step = 1'b0;
         chk("wait_req", 64'(imem_req), 64'(1));
         chk("wait_addr", 64'(imem_addr), 64'(exp_pc));
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      step       = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      chk("dec_ireg", 64'(iReg), 64'(word));
      chk("dec_req", 64'(imem_req), 64'(0));
      chk("dec_rfwe", 64'(rf_we), 64'(0));
      if (word[6:0] == 7'h7F) begin
         tick();
         chk("halt_flag", 64'(halted), 64'(1));
         chk("halt_busy", 64'(busy), 64'(0));
         chk("halt_pc", 64'(pc), 64'(exp_pc));
         chk("halt_ret", 64'(retired), 64'(exp_ret));
         return;
      end
      run = run_next;
      tick();
      chk("exec_rfwe", 64'(rf_we), 64'(0));
      chk("exec_busy", 64'(busy), 64'(1));
      if (spurious) begin
         imem_ack   = 1'b1;
         imem_rdata = $urandom;
      end
      tick();
      imem_ack = 1'b0;
      chk("wb_ireg", 64'(iReg), 64'(word));
      chk("wb_rfwe", 64'(rf_we), 64'(word[11:7] != 5'd0));
      chk("wb_pc", 64'(pc), 64'(exp_pc));
      tick();
      exp_pc  = exp_pc + 16'd1;
      exp_ret = exp_ret + 32'd1;
      cont    = run_next && !single_m;
      chk("post_pc", 64'(pc), 64'(exp_pc));
      chk("post_ret", 64'(retired), 64'(exp_ret));
      chk("post_rfwe", 64'(rf_we), 64'(0));
      chk("post_req", 64'(imem_req), 64'(cont));
      chk("post_busy", 64'(busy), 64'(cont));
      single_m = 1'b0;
      in_idle  = !cont;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      step = 1'b0;
      imem_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_pc = '0;
      exp_ret = '0;
      single_m = 1'b0;
      in_idle = 1'b1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_req"}, 64'(imem_req), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_halted"}, 64'(halted), 64'(0));
      chk({tag, "_rfwe"}, 64'(rf_we), 64'(0));
   endtask

   initial begin
      logic [31:0] word;
      rst = 1'b1; run = 1'b0; step = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      w_rst = 1'b1; w_run = 1'b0; w_step = 1'b0; w_ack = 1'b1; w_rdata = 32'h0000_0081;
      exp_pc = '0; exp_ret = '0; single_m = 1'b0; in_idle = 1'b1;

      // Reset values held with run low
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_idle("rst_idle");
         chk("rst_pc", 64'(pc), 64'(0));
         chk("rst_ireg", 64'(iReg), 64'(0));
         chk("rst_ret", 64'(retired), 64'(0));
      end

      // Zero-wait run into HALT
      run = 1'b1;
      do_instr(32'h0014_0082, 0, 1'b1, 1'b0, 1'b0);
      do_instr(32'h0000_007F, 0, 1'b1, 1'b0, 1'b0);
      imem_ack = 1'b1;
      tick(); tick(); tick();
      imem_ack = 1'b0;
      chk("halt_stay", 64'(halted), 64'(1));
      chk("halt_stay_pc", 64'(pc), 64'(1));
      chk("halt_stay_ret", 64'(retired), 64'(1));
      chk("halt_stay_ireg", 64'(iReg), 64'(32'h0000_007F));
      chk("halt_stay_req", 64'(imem_req), 64'(0));

      // Three wait cycles with a spurious EXEC ack, then a nop ending the run
      do_reset();
      chk_idle("rst2");
      run = 1'b1;
      do_instr(32'h1234_5193, 3, 1'b1, 1'b1, 1'b0);
      do_instr(32'h0000_0000, 0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_idle("after_drop");

      // Single step with run low
      step = 1'b1;
      single_m = 1'b1;
      tick();
      step = 1'b0;
      do_instr(32'h0004_1181, 0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      chk_idle("after_step");
      chk("after_step_ret", 64'(retired), 64'(exp_ret));

      // run and step together: run wins, execution continues
      run = 1'b1;
      step = 1'b1;
      single_m = 1'b0;
      tick();
      step = 1'b0;
      do_instr(32'h0000_0313, 0, 1'b1, 1'b0, 1'b0);
      // step outside IDLE is ignored; run dropped so the block parks in IDLE
      do_instr(32'h0000_0393, 2, 1'b0, 1'b0, 1'b1);
      tick(); tick(); tick();
      chk_idle("step_ignored");

      // Randomized instructions, waits, run drops and step starts
      for (int n = 0; n < 30; n++) begin
         if (in_idle) begin
            if ($urandom_range(1, 0) == 1) begin
               run = 1'b1;
               tick();
            end else begin
               run = 1'b0;
               step = 1'b1;
               single_m = 1'b1;
               tick();
               step = 1'b0;
            end
         end
         word = $urandom;
         if (word[6:0] == 7'h7F) word[6:0] = 7'h13;
         do_instr(word, int'($urandom_range(3, 0)), ($urandom_range(3, 0) != 0),
                  ($urandom_range(1, 0) == 1), 1'b0);
      end

      // Reset during the second wait cycle of a fetch at pc=5
      do_reset();
      run = 1'b1;
      for (int k = 0; k < 5; k++) begin
         word = $urandom;
         if (word[6:0] == 7'h7F) word[6:0] = 7'h13;
         do_instr(word, 0, 1'b1, 1'b0, 1'b0);
      end
      chk("rf5_addr", 64'(imem_addr), 64'(16'd5));
      chk("rf5_req", 64'(imem_req), 64'(1));
      imem_ack = 1'b0;
      tick();
      chk("rf5_wait2_req", 64'(imem_req), 64'(1));
      rst = 1'b1;
      run = 1'b0;
      tick();
      rst = 1'b0;
      chk_idle("rf5_rst");
      chk("rf5_pc", 64'(pc), 64'(0));
      chk("rf5_ret", 64'(retired), 64'(0));
      chk("rf5_ireg", 64'(iReg), 64'(0));
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      tick();
      chk_idle("late_ack");
      chk("late_ack_ireg", 64'(iReg), 64'(0));

      // PC wrap on the 3-bit instance with zero-wait memory
      w_rst = 1'b0;
      w_run = 1'b1;
      for (int c = 0; c < 29; c++) tick();
      chk("wrap_pc7", 64'(w_pc), 64'(3'd7));
      chk("wrap_ret7", 64'(w_retired), 64'(7));
      for (int c = 0; c < 4; c++) tick();
      chk("wrap_pc0", 64'(w_pc), 64'(3'd0));
      chk("wrap_ret8", 64'(w_retired), 64'(8));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_scpu_sequencer
